// File: rtl/apb_timer_if.sv
// APB slave bus bundle for the timer.
// Signals:
//   paddr   - byte address (only [11:0] decoded by the timer)
//   psel    - slave select
//   penable - access phase qualifier
//   pwrite  - 1 = write, 0 = read
//   pwdata  - write data
//   prdata  - read data, driven by the slave
// Modports: master (bridge/testbench side), slave (timer side).
interface apb_timer_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata
  );
endinterface

// File: rtl/apb_timer.sv
// APB-programmable down-counting timer with prescaler and level interrupt.
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   rstn  - asynchronous active-low reset
//   apb   - APB slave bundle (zero wait states, no pready/pslverr)
//   irq   - level interrupt = STATUS.IF && CTRL.IRQ_EN
// Register map (paddr[11:0]):
//   0x00 CTRL     bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
//   0x04 LOAD     reload value
//   0x08 VALUE    current count (read-only)
//   0x0C STATUS   bit0 IF, write 1 to clear
//   0x10 PRESCALE PRESC_W bits, zero-extended on read
module apb_timer #(
  parameter int PRESC_W = 8
) (
  input  logic       clk,
  input  logic       rstn,
  apb_timer_if.slave apb,
  output logic       irq
);

  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_LOAD   = 12'h004;
  localparam logic [11:0] OFF_VALUE  = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;
  localparam logic [11:0] OFF_PRESC  = 12'h010;

  // Register state
  logic               en_r;
  logic               periodic_r;
  logic               irq_en_r;
  logic               if_r;
  logic [31:0]        load_r;
  logic [31:0]        value_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] cnt_r;

  // Next-state values
  logic               en_s;
  logic               periodic_s;
  logic               irq_en_s;
  logic               if_s;
  logic [31:0]        load_s;
  logic [31:0]        value_s;
  logic [PRESC_W-1:0] presc_s;
  logic [PRESC_W-1:0] cnt_s;

  logic [11:0]        offset_s;
  logic               wr_s;
  logic               wr_ctrl_s;
  logic               wr_load_s;
  logic               wr_stat_s;
  logic               wr_presc_s;
  logic               tick_s;
  logic               expire_s;
  logic [31:0]        rdata_s;
  logic               unused_addr_bits;

  assign offset_s   = apb.paddr[11:0];
  assign wr_s       = apb.psel & apb.penable & apb.pwrite;
  assign wr_ctrl_s  = wr_s & (offset_s == OFF_CTRL);
  assign wr_load_s  = wr_s & (offset_s == OFF_LOAD);
  assign wr_stat_s  = wr_s & (offset_s == OFF_STATUS);
  assign wr_presc_s = wr_s & (offset_s == OFF_PRESC);

  // The prescaler compares against the live PRESCALE, so a smaller new value
  // than the current count makes the count run up through its maximum first.
  assign tick_s   = en_r & (cnt_r == presc_r);
  assign expire_s = tick_s & (value_r == 32'd0);

  assign unused_addr_bits = ^apb.paddr[31:12];

  // Next-state logic: countdown first, then bus writes override where they collide
  always_comb begin
    en_s       = en_r;
    periodic_s = periodic_r;
    irq_en_s   = irq_en_r;
    if_s       = if_r;
    load_s     = load_r;
    value_s    = value_r;
    presc_s    = presc_r;
    cnt_s      = cnt_r;

    if (en_r) begin
      if (tick_s) begin
        cnt_s = {PRESC_W{1'b0}};
        if (value_r != 32'd0) begin
          value_s = value_r - 32'd1;
        end else if (periodic_r) begin
          value_s = load_r;
        end else begin
          // one-shot expiry: stop, VALUE stays at 0
          en_s = 1'b0;
        end
      end else begin
        cnt_s = cnt_r + PRESC_W'(1);
      end
    end else begin
      cnt_s = {PRESC_W{1'b0}};
    end

    // A CTRL write beats a same-edge one-shot expiry for EN.
    if (wr_ctrl_s) begin
      en_s       = apb.pwdata[0];
      periodic_s = apb.pwdata[1];
      irq_en_s   = apb.pwdata[2];
      if (!apb.pwdata[0]) begin
        value_s = value_r;
        cnt_s   = {PRESC_W{1'b0}};
      end else if (!en_r) begin
        value_s = load_r;
        cnt_s   = {PRESC_W{1'b0}};
      end else begin
        // already running: keep the countdown result computed above
        value_s = value_s;
      end
    end else begin
      en_s = en_s;
    end

    if (wr_load_s) begin
      load_s = apb.pwdata;
    end else begin
      load_s = load_r;
    end

    if (wr_presc_s) begin
      presc_s = apb.pwdata[PRESC_W-1:0];
    end else begin
      presc_s = presc_r;
    end

    // Expiry set wins over a same-edge write-1-to-clear.
    if (expire_s) begin
      if_s = 1'b1;
    end else if (wr_stat_s && apb.pwdata[0]) begin
      if_s = 1'b0;
    end else begin
      if_s = if_r;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_r       <= 1'b0;
      periodic_r <= 1'b0;
      irq_en_r   <= 1'b0;
      if_r       <= 1'b0;
      load_r     <= 32'd0;
      value_r    <= 32'd0;
      presc_r    <= {PRESC_W{1'b0}};
      cnt_r      <= {PRESC_W{1'b0}};
    end else begin
      en_r       <= en_s;
      periodic_r <= periodic_s;
      irq_en_r   <= irq_en_s;
      if_r       <= if_s;
      load_r     <= load_s;
      value_r    <= value_s;
      presc_r    <= presc_s;
      cnt_r      <= cnt_s;
    end
  end

  // Read mux; unmapped offsets (including paddr[11:5] != 0) read 0
  always_comb begin
    rdata_s = 32'd0;
    case (offset_s)
      OFF_CTRL:   rdata_s = {29'd0, irq_en_r, periodic_r, en_r};
      OFF_LOAD:   rdata_s = load_r;
      OFF_VALUE:  rdata_s = value_r;
      OFF_STATUS: rdata_s = {31'd0, if_r};
      OFF_PRESC:  rdata_s = 32'(presc_r);
      default:    rdata_s = 32'd0;
    endcase
  end

  // prdata is combinational so the bridge can sample it in the access phase
  assign apb.prdata = (apb.psel && !apb.pwrite) ? rdata_s : 32'd0;
  assign irq        = if_r & irq_en_r;

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: a register-access vector table followed
// by hand-written cycle-exact sequences for counting, collisions and reset.
module tb_apb_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_LOAD   = 32'h0000_0004;
  localparam logic [31:0] A_VALUE  = 32'h0000_0008;
  localparam logic [31:0] A_STATUS = 32'h0000_000C;
  localparam logic [31:0] A_PRESC  = 32'h0000_0010;

  logic clk = 1'b0;
  logic rstn;
  logic irq;
  int   cyc = 0;

  apb_timer_if bus();

  apb_timer #(.PRESC_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .apb  (bus),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sb_compare(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_underflow: got 0x%08h, expected nothing", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.data);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.paddr   = addr;
    bus.pwdata  = data;
    bus.pwrite  = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    bus.paddr   = addr;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    e.name = name;
    e.data = exp;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1;
    sb_compare(bus.prdata);
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // Combinational look at a register between edges (prdata valid on psel && !pwrite)
  task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    bus.paddr   = addr;
    bus.pwrite  = 1'b0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    e.name = name;
    e.data = exp;
    sb_q.push_back(e);
    #1;
    sb_compare(bus.prdata);
    bus.psel = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic add_w(input logic [31:0] addr, input logic [31:0] data);
    vec_t v;
    v.wr = 1'b1; v.addr = addr; v.data = data; v.exp = 32'd0; v.name = "wr";
    vecs.push_back(v);
  endtask

  task automatic add_r(input logic [31:0] addr, input logic [31:0] exp, input string name);
    vec_t v;
    v.wr = 1'b0; v.addr = addr; v.data = 32'd0; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    int e;
    rstn        = 1'b0;
    bus.paddr   = 32'd0;
    bus.pwdata  = 32'd0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;

    // register access table
    add_r(A_CTRL,   32'h0000_0000, "rst_ctrl");
    add_r(A_LOAD,   32'h0000_0000, "rst_load");
    add_r(A_VALUE,  32'h0000_0000, "rst_value");
    add_r(A_STATUS, 32'h0000_0000, "rst_status");
    add_r(A_PRESC,  32'h0000_0000, "rst_presc");
    add_w(A_LOAD,   32'hFFFF_FFFF);
    add_r(A_LOAD,   32'hFFFF_FFFF, "load_rw");
    add_w(A_PRESC,  32'hFFFF_FFFF);
    add_r(A_PRESC,  32'h0000_00FF, "presc_rw");
    add_w(32'h14,   32'hFFFF_FFFF);
    add_r(32'h14,   32'h0000_0000, "unmapped_14");
    add_w(32'h20,   32'hFFFF_FFFF);
    add_r(32'h20,   32'h0000_0000, "unmapped_20");
    add_w(A_VALUE,  32'hFFFF_FFFF);
    add_r(A_VALUE,  32'h0000_0000, "value_ro");
    add_w(A_STATUS, 32'hFFFF_FFFF);
    add_r(A_STATUS, 32'h0000_0000, "status_idle");
    add_w(A_CTRL,   32'hFFFF_FFFF);
    add_r(A_CTRL,   32'h0000_0007, "ctrl_rw");
    add_r(A_VALUE,  32'hFFFF_FFFF, "value_loaded");
    add_r(32'h4001_1004, 32'hFFFF_FFFF, "addr_hi_ignored");
    add_r(32'h0000_0001, 32'h0000_0000, "misaligned");
    add_r(32'h0000_0804, 32'h0000_0000, "addr_11_5");
    add_w(A_CTRL,   32'h0000_0000);
    add_r(A_CTRL,   32'h0000_0000, "ctrl_off");
    add_r(A_VALUE,  32'hFFFF_FFFF, "value_frozen");

    #2;
    check("rst_prdata_idle", bus.prdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    #21;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else            apb_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // one-shot: PRESCALE=0, LOAD=3, CTRL=EN|IRQ_EN
    apb_write(A_PRESC, 32'd0);
    apb_write(A_LOAD, 32'd3);
    apb_write(A_CTRL, 32'h5);
    e = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_cyc(e + k);
      peek(A_VALUE, 32'(3 - k), "oneshot_value");
    end
    check("oneshot_irq_early", {31'd0, irq}, 32'd0);
    wait_cyc(e + 4);
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    peek(A_STATUS, 32'd1, "oneshot_if");
    peek(A_CTRL, 32'h4, "oneshot_en_off");
    wait_cyc(e + 8);
    peek(A_VALUE, 32'd0, "oneshot_value_hold");

    // irq gated by IRQ_EN while IF stays set
    apb_write(A_CTRL, 32'd0);
    check("irq_gated", {31'd0, irq}, 32'd0);
    peek(A_STATUS, 32'd1, "if_kept");
    apb_write(A_STATUS, 32'd1);
    peek(A_STATUS, 32'd0, "if_cleared");

    // periodic prescaled: PRESCALE=2, LOAD=1 -> expiry every 6 cycles
    apb_write(A_PRESC, 32'd2);
    apb_write(A_LOAD, 32'd1);
    apb_write(A_CTRL, 32'h3);
    e = cyc;
    wait_cyc(e + 3);
    peek(A_VALUE, 32'd0, "per_value_tick");
    wait_cyc(e + 5);
    peek(A_STATUS, 32'd0, "per_if_before");
    wait_cyc(e + 6);
    peek(A_STATUS, 32'd1, "per_if_set1");
    peek(A_VALUE, 32'd1, "per_reload1");
    check("per_irq_masked", {31'd0, irq}, 32'd0);
    apb_write(A_STATUS, 32'd1);
    peek(A_STATUS, 32'd0, "per_if_clr");
    wait_cyc(e + 11);
    peek(A_STATUS, 32'd0, "per_if_before2");
    wait_cyc(e + 12);
    peek(A_STATUS, 32'd1, "per_if_set2");
    peek(A_VALUE, 32'd1, "per_reload2");
    apb_write(A_STATUS, 32'd1);
    // clear lands exactly on the expiry edge e+18
    wait_cyc(e + 16);
    apb_write(A_STATUS, 32'd1);
    peek(A_STATUS, 32'd1, "collide_status");

    // one-shot expiry colliding with CTRL=0 and with CTRL=EN
    apb_write(A_CTRL, 32'd0);
    apb_write(A_STATUS, 32'd1);
    apb_write(A_PRESC, 32'd0);
    apb_write(A_LOAD, 32'd2);
    apb_write(A_CTRL, 32'h1);
    e = cyc;
    wait_cyc(e + 1);
    apb_write(A_CTRL, 32'd0);
    peek(A_CTRL, 32'd0, "collide_ctrl0_en");
    peek(A_STATUS, 32'd1, "collide_ctrl0_if");
    apb_write(A_STATUS, 32'd1);
    apb_write(A_CTRL, 32'h1);
    e = cyc;
    wait_cyc(e + 1);
    apb_write(A_CTRL, 32'h1);
    peek(A_CTRL, 32'h1, "collide_ctrl1_en");
    peek(A_STATUS, 32'd1, "collide_ctrl1_if");
    peek(A_VALUE, 32'd0, "collide_ctrl1_value");
    apb_write(A_CTRL, 32'd0);
    apb_write(A_STATUS, 32'd1);

    // live LOAD update: period 6 ticks then 3 ticks
    apb_write(A_LOAD, 32'd5);
    apb_write(A_CTRL, 32'h3);
    e = cyc;
    apb_write(A_LOAD, 32'd2);
    peek(A_VALUE, 32'd3, "live_value_kept");
    wait_cyc(e + 5);
    peek(A_VALUE, 32'd0, "live_value_zero");
    peek(A_STATUS, 32'd0, "live_if_before");
    wait_cyc(e + 6);
    peek(A_STATUS, 32'd1, "live_if_set");
    peek(A_VALUE, 32'd2, "live_reload_new");
    wait_cyc(e + 8);
    peek(A_VALUE, 32'd0, "live_value_zero2");
    wait_cyc(e + 9);
    peek(A_VALUE, 32'd2, "live_reload2");
    apb_write(A_CTRL, 32'd0);

    // reset mid-count (IF still set, IRQ_EN on -> irq high before reset)
    apb_write(A_LOAD, 32'd100);
    apb_write(A_CTRL, 32'h5);
    e = cyc;
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    wait_cyc(e + 60);
    peek(A_VALUE, 32'd40, "pre_rst_value");
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    peek(A_CTRL,   32'd0, "rst_mid_ctrl");
    peek(A_LOAD,   32'd0, "rst_mid_load");
    peek(A_VALUE,  32'd0, "rst_mid_value");
    peek(A_STATUS, 32'd0, "rst_mid_status");
    peek(A_PRESC,  32'd0, "rst_mid_presc");
    @(posedge clk); @(posedge clk); #3;
    rstn = 1'b1;
    apb_write(A_LOAD, 32'd7);
    apb_read(A_LOAD, 32'd7, "post_rst_first_write");
    wait_cyc(cyc + 150);
    peek(A_STATUS, 32'd0, "post_rst_no_expiry");
    peek(A_VALUE, 32'd0, "post_rst_value");
    peek(A_CTRL, 32'd0, "post_rst_ctrl");
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
